// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin packet arbiter feeding one shared FIFO write port.
// A granted requester keeps ownership until its last word is written.
module fifo_wr_arbiter_rr #(
  parameter int NumPorts   = 4,
  parameter int DataWidth  = 32,
  parameter int CountWidth = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumPorts-1:0]           in_valid,
  input  logic [NumPorts-1:0]           in_last,
  input  logic [NumPorts*DataWidth-1:0] in_data,
  output logic [NumPorts-1:0]           in_ready,
  output logic                          fifo_wr_req,
  output logic [DataWidth-1:0]          fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic [NumPorts-1:0]           grant,
  output logic [CountWidth-1:0]         pkt_count
);

  localparam int IdxW = $clog2(NumPorts);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                state_q, state_d;
  logic [NumPorts-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]       gidx_q, gidx_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [CountWidth-1:0] cnt_q, cnt_d;

  logic            found;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] cand;
  logic            g_valid;
  logic            g_last;
  logic            xfer;

  // First valid port strictly after the last one served, with wrap.
  always_comb begin
    found = 1'b0;
    sel   = last_q;
    cand  = last_q;
    for (int i = 1; i <= NumPorts; i++) begin
      cand = IdxW'((int'(last_q) + i) % NumPorts);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Grant is all zero in IDLE, so the datapath self-gates.
  always_comb begin
    g_valid      = |(in_valid & grant_q);
    g_last       = |(in_last & grant_q);
    xfer         = g_valid && !fifo_wr_full;
    in_ready     = fifo_wr_full ? '0 : grant_q;
    fifo_wr_req  = xfer;
    fifo_wr_data = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (grant_q[p]) begin
        fifo_wr_data = in_data[p*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          grant_d = NumPorts'(1) << sel;
          gidx_d  = sel;
        end
      end
      LOCKED: begin
        if (xfer && g_last) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IdxW'(NumPorts - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// Bench for fifo_wr_arbiter_rr: requester queues drive the DUT,
// a packet-level reference model predicts every cycle's outputs.
module tb_fifo_wr_arbiter_rr;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_last;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_ready;
  logic              fifo_wr_req;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_wr_full;
  logic [NP-1:0]     grant;
  logic [CW-1:0]     pkt_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter_rr #(
    .NumPorts  (NP),
    .DataWidth (DW),
    .CountWidth(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .fifo_wr_req (fifo_wr_req),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full),
    .grant       (grant),
    .pkt_count   (pkt_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 idle), last served, packets done.
  int m_owner;
  int m_last;
  int m_count;

  // Requester word queues.
  logic [31:0] sd [NP][512];
  bit          sl [NP][512];
  int          hd [NP];
  int          tl [NP];

  int full_from = 0;
  int full_to   = 0;
  int full_pct  = 0;
  int gap_pct   = 0;

  logic [31:0] dlog[$];
  int          gseq[$];

  task automatic model_reset();
    m_owner = -1;
    m_last  = NP - 1;
    m_count = 0;
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      hd[p] = 0;
      tl[p] = 0;
    end
    dlog.delete();
    gseq.delete();
  endtask

  task automatic add_pkt(input int p, input int len, input logic [31:0] base);
    for (int k = 0; k < len; k++) begin
      sd[p][tl[p]] = base + k;
      sl[p][tl[p]] = (k == len - 1);
      tl[p]++;
    end
  endtask

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (hd[p] < tl[p]) e = 1'b0;
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    in_valid     = '0;
    in_last      = '0;
    in_data      = '0;
    fifo_wr_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    clear_src();
  endtask

  // Drive requesters for up to max_cyc cycles, checking each cycle.
  task automatic run(input int max_cyc, input bit need_done, output int cyc);
    logic [NP-1:0] v, l, eg, er, acc, prev_g;
    logic [31:0]   d [NP];
    logic [31:0]   edata;
    logic          ereq;
    bit            fl;
    int            gi;
    cyc    = 0;
    prev_g = grant;
    while (cyc < max_cyc && !(need_done && srcs_empty() && m_owner < 0)) begin
      for (int p = 0; p < NP; p++) begin
        if (hd[p] < tl[p]) begin
          v[p] = ($urandom_range(99) >= gap_pct);
          d[p] = sd[p][hd[p]];
          l[p] = sl[p][hd[p]];
        end else begin
          v[p] = 1'b0;
          d[p] = $urandom;
          l[p] = 1'($urandom);
        end
        in_data[p*DW +: DW] = d[p];
      end
      fl = (cyc >= full_from && cyc < full_to) ||
           ($urandom_range(99) < full_pct);
      in_valid     = v;
      in_last      = l;
      fifo_wr_full = fl;
      #1;
      eg    = '0;
      er    = '0;
      ereq  = 1'b0;
      edata = '0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        er    = fl ? '0 : eg;
        ereq  = v[m_owner] && !fl;
        edata = d[m_owner];
      end
      checks += 5;
      if (grant !== eg) begin
        errors++;
        $display("FAIL grant cyc=%0d: got %b want %b", cyc, grant, eg);
      end
      if (in_ready !== er) begin
        errors++;
        $display("FAIL in_ready cyc=%0d: got %b want %b", cyc, in_ready, er);
      end
      if (fifo_wr_req !== ereq) begin
        errors++;
        $display("FAIL wr_req cyc=%0d: got %b want %b", cyc, fifo_wr_req, ereq);
      end
      if (fifo_wr_data !== edata) begin
        errors++;
        $display("FAIL wr_data cyc=%0d: got %h want %h", cyc, fifo_wr_data, edata);
      end
      if (pkt_count !== CW'(m_count)) begin
        errors++;
        $display("FAIL pkt_count cyc=%0d: got %0d want %0d", cyc, pkt_count, m_count);
      end
      if (grant != '0 && grant != prev_g) begin
        gi = 0;
        for (int p = 0; p < NP; p++) if (grant[p]) gi = p;
        gseq.push_back(gi);
      end
      prev_g = grant;
      if (fifo_wr_req) dlog.push_back(fifo_wr_data);
      acc = in_valid & in_ready;
      @(posedge clk);
      if (m_owner < 0) begin
        for (int i = 1; i <= NP; i++) begin
          if (m_owner < 0 && v[(m_last + i) % NP]) m_owner = (m_last + i) % NP;
        end
      end else if (v[m_owner] && !fl && l[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
        if (m_count < CMAX) m_count++;
      end
      for (int p = 0; p < NP; p++) if (acc[p]) hd[p]++;
      #1;
      cyc++;
    end
    if (need_done && !(srcs_empty() && m_owner < 0)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d cycles without draining, want done", cyc);
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (grant !== '0) begin
      errors++;
      $display("FAIL reset_grant: got %b want 0", grant);
    end
    if (fifo_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b want 0", fifo_wr_req);
    end
    if (pkt_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", pkt_count);
    end
    do_reset();
    run(10, 1'b0, c);
  endtask

  task automatic test_four_packets();
    int c;
    clear_src();
    for (int p = 0; p < NP; p++) add_pkt(p, 3, 32'(p * 16));
    run(100, 1'b1, c);
    checks += 3;
    if (c != 16) begin
      errors++;
      $display("FAIL four_cycles: got %0d want 16", c);
    end
    if (pkt_count !== CW'(4)) begin
      errors++;
      $display("FAIL four_count: got %0d want 4", pkt_count);
    end
    if (dlog.size() != 12) begin
      errors++;
      $display("FAIL four_words: got %0d want 12", dlog.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (dlog[i] !== 32'((i / 3) * 16 + (i % 3))) begin
          errors++;
          $display("FAIL four_order[%0d]: got %0d want %0d",
                   i, dlog[i], (i / 3) * 16 + (i % 3));
        end
      end
    end
  endtask

  task automatic test_full_stall();
    int c;
    clear_src();
    add_pkt(2, 4, 32'd100);
    full_from = 2;
    full_to   = 7;
    run(100, 1'b1, c);
    full_from = 0;
    full_to   = 0;
    checks += 3;
    if (c != 10) begin
      errors++;
      $display("FAIL stall_cycles: got %0d want 10", c);
    end
    if (gseq.size() != 1 || gseq[0] != 2) begin
      errors++;
      $display("FAIL stall_grant: got %0d grant runs want one on port 2", gseq.size());
    end
    if (dlog.size() != 4) begin
      errors++;
      $display("FAIL stall_words: got %0d want 4", dlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dlog[i] !== 32'(100 + i)) begin
          errors++;
          $display("FAIL stall_data[%0d]: got %0d want %0d", i, dlog[i], 100 + i);
        end
      end
    end
  endtask

  task automatic test_alternate();
    int c;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      add_pkt(1, 1, 32'h100 + n);
      add_pkt(3, 1, 32'h300 + n);
    end
    run(100, 1'b1, c);
    checks += 2;
    if (c != 32) begin
      errors++;
      $display("FAIL alt_cycles: got %0d want 32", c);
    end
    if (gseq.size() != 16) begin
      errors++;
      $display("FAIL alt_grants: got %0d want 16", gseq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (gseq[i] != ((i % 2 == 0) ? 1 : 3)) begin
          errors++;
          $display("FAIL alt_order[%0d]: got %0d want %0d",
                   i, gseq[i], (i % 2 == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    do_reset();
    add_pkt(3, 4, 32'h30);
    run(2, 1'b0, c);
    in_valid = 4'b1000;
    in_last  = '0;
    in_data[3*DW +: DW] = 32'h31;
    fifo_wr_full = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 6;
    if (grant !== '0) begin
      errors++;
      $display("FAIL mid_grant: got %b want 0", grant);
    end
    if (in_ready !== '0) begin
      errors++;
      $display("FAIL mid_ready: got %b want 0", in_ready);
    end
    if (fifo_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_req: got %b want 0", fifo_wr_req);
    end
    if (fifo_wr_data !== '0) begin
      errors++;
      $display("FAIL mid_data: got %h want 0", fifo_wr_data);
    end
    if (pkt_count !== '0) begin
      errors++;
      $display("FAIL mid_count: got %0d want 0", pkt_count);
    end
    if (dlog.size() != 1) begin
      errors++;
      $display("FAIL mid_words: got %0d want 1", dlog.size());
    end
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    clear_src();
    add_pkt(0, 2, 32'hA0);
    add_pkt(3, 4, 32'h30);
    run(100, 1'b1, c);
    checks += 2;
    if (gseq.size() == 0 || gseq[0] != 0) begin
      errors++;
      $display("FAIL mid_restart: got first grant %0d want 0",
               (gseq.size() == 0) ? -1 : gseq[0]);
    end
    if (dlog.size() == 0 || dlog[0] !== 32'hA0) begin
      errors++;
      $display("FAIL mid_first_word: got %h want a0",
               (dlog.size() == 0) ? 32'hx : dlog[0]);
    end
  endtask

  task automatic test_random();
    int c;
    int total;
    do_reset();
    total = 0;
    for (int p = 0; p < NP; p++) begin
      for (int n = 0; n < 12; n++) begin
        int len;
        len = int'($urandom_range(4, 1));
        add_pkt(p, len, (32'(p) << 24) | (32'(n) << 8));
        total += len;
      end
    end
    gap_pct  = 25;
    full_pct = 20;
    run(5000, 1'b1, c);
    gap_pct  = 0;
    full_pct = 0;
    checks++;
    if (dlog.size() != total) begin
      errors++;
      $display("FAIL rand_words: got %0d want %0d", dlog.size(), total);
    end
  endtask

  task automatic test_saturate();
    int c;
    do_reset();
    for (int n = 0; n < 300; n++) add_pkt(0, 1, 32'(n));
    run(1000, 1'b1, c);
    checks += 2;
    if (pkt_count !== CW'(CMAX)) begin
      errors++;
      $display("FAIL sat_count: got %0d want %0d", pkt_count, CMAX);
    end
    if (c != 600) begin
      errors++;
      $display("FAIL sat_cycles: got %0d want 600", c);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = '0;
    in_last      = '0;
    in_data      = '0;
    fifo_wr_full = 1'b0;
    model_reset();
    clear_src();
    test_reset();
    test_four_packets();
    test_full_stall();
    test_alternate();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
